reset_sequencer: RTL

//  Sits directly downstream of the reset synchronizer and consumes its rst_n.

---
 rtl/reset_sequencer_if.sv | 36 +++
 rtl/reset_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// Reset sequencer signal bundle: memory-init handshake, soft-reset handshake
// and the staged reset/status outputs.
interface reset_sequencer_if;
  logic mem_init_done;
  logic soft_rst_req;
  logic mem_rst_n;
  logic periph_rst_n;
  logic cpu_rst_n;
  logic sys_ready;
  logic soft_rst_ack;
  logic init_err;

  // Sequencer side: consumes handshakes, drives resets and status.
  modport master (
    input  mem_init_done,
    input  soft_rst_req,
    output mem_rst_n,
    output periph_rst_n,
    output cpu_rst_n,
    output sys_ready,
    output soft_rst_ack,
    output init_err
  );

  // System side: drives handshakes, observes resets and status.
  modport slave (
    output mem_init_done,
    output soft_rst_req,
    input  mem_rst_n,
    input  periph_rst_n,
    input  cpu_rst_n,
    input  sys_ready,
    input  soft_rst_ack,
    input  init_err
  );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: releases memory, peripheral and CPU resets in a fixed
// timed order, waits on memory init, handles soft resets and init timeouts.
module reset_sequencer #(
  parameter int unsigned MEM_DELAY    = 16,
  parameter int unsigned PERIPH_DELAY = 8,
  parameter int unsigned CPU_DELAY    = 4,
  parameter int unsigned INIT_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  reset_sequencer_if.master  bus
);

  localparam int unsigned MAX_AB = (MEM_DELAY > PERIPH_DELAY) ? MEM_DELAY : PERIPH_DELAY;
  localparam int unsigned MAX_CD = (CPU_DELAY > INIT_TIMEOUT) ? CPU_DELAY : INIT_TIMEOUT;
  localparam int unsigned MAX_D  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W  = $clog2(MAX_D) + 1;

  // Terminal counts: a timed state leaves on the edge that sees its last count.
  localparam logic [CNT_W-1:0] MEM_LAST    = CNT_W'(MEM_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);
  localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_DELAY - 1);
  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_MEM_HOLD,
    S_MEM_INIT,
    S_PERIPH_HOLD,
    S_CPU_HOLD,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_inc;
  logic             accept;
  logic             timeout;

  // Next-state decode; done beats timeout when both land on the same edge.
  always_comb begin
    nxt     = state;
    cnt_inc = 1'b0;
    accept  = 1'b0;
    timeout = 1'b0;
    case (state)
      S_RESET:       nxt = S_MEM_HOLD;
      S_MEM_HOLD: begin
        cnt_inc = 1'b1;
        if (cnt == MEM_LAST) nxt = S_MEM_INIT;
      end
      S_MEM_INIT: begin
        cnt_inc = 1'b1;
        if (bus.mem_init_done) begin
          nxt = S_PERIPH_HOLD;
        end else if (cnt == INIT_LAST) begin
          nxt     = S_FAULT;
          timeout = 1'b1;
        end
      end
      S_PERIPH_HOLD: begin
        cnt_inc = 1'b1;
        if (cnt == PERIPH_LAST) nxt = S_CPU_HOLD;
      end
      S_CPU_HOLD: begin
        cnt_inc = 1'b1;
        if (cnt == CPU_LAST) nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.soft_rst_req) begin
          nxt    = S_PERIPH_HOLD;
          accept = 1'b1;
        end
      end
      S_FAULT: begin
        if (bus.soft_rst_req) begin
          nxt    = S_MEM_HOLD;
          accept = 1'b1;
        end
      end
      default:       nxt = S_RESET;
    endcase
  end

  // State, counter and outputs register together; outputs decode the next state
  // so they change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_RESET;
      cnt              <= '0;
      bus.mem_rst_n    <= 1'b0;
      bus.periph_rst_n <= 1'b0;
      bus.cpu_rst_n    <= 1'b0;
      bus.sys_ready    <= 1'b0;
      bus.soft_rst_ack <= 1'b0;
      bus.init_err     <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      bus.mem_rst_n    <= (nxt != S_RESET) && (nxt != S_MEM_HOLD);
      bus.periph_rst_n <= (nxt == S_CPU_HOLD) || (nxt == S_RUN);
      bus.cpu_rst_n    <= (nxt == S_RUN);
      bus.sys_ready    <= (nxt == S_RUN);
      bus.soft_rst_ack <= accept;
      bus.init_err     <= bus.init_err | timeout;
    end
  end

endmodule
